// File: rtl/ram_inout_arbiter.sv
// Round-robin arbiter/sequencer for two masters onto a 16x8 single-port RAM with a shared tri-state data bus.
// Write takes 3 cycles and read takes 4, grant to IDLE; a master holds req until it sees its ack, and the other master waits meanwhile.
module ram_inout_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              cs,
    output logic              wr,
    output logic [ADDR_W-1:0] add,
    inout  wire  [DATA_W-1:0] data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ1 = 3'd2,
        READ2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              lwr_q, lwr_d;
    logic [ADDR_W-1:0] add_q, add_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        lwr_d    = lwr_q;
        add_d    = add_q;
        wdat_d   = wdat_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the master that did not win last time goes first.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    last_d  = gnt_d;
                    lwr_d   = gnt_d ? wr1 : wr0;
                    add_d   = gnt_d ? addr1 : addr0;
                    wdat_d  = gnt_d ? wdata1 : wdata0;
                    state_d = lwr_d ? WRITE : READ1;
                end
            end
            WRITE: state_d = DONE;
            READ1: state_d = READ2;
            READ2: begin
                state_d = DONE;
                if (gnt_q) begin
                    rdata1_d = data;
                end else begin
                    rdata0_d = data;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        cs_d   = (state_d == WRITE) || (state_d == READ1) || (state_d == READ2);
        wr_d   = (state_d == WRITE);
        busy_d = (state_d != IDLE);
        ack0_d = (state_d == DONE) && !gnt_d;
        ack1_d = (state_d == DONE) && gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            lwr_q    <= 1'b0;
            add_q    <= '0;
            wdat_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            lwr_q    <= lwr_d;
            add_q    <= add_d;
            wdat_q   <= wdat_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cs_q     <= cs_d;
            wr_q     <= wr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    // Drive only in WRITE; DONE always separates this from any read cycle.
    assign data   = (state_q == WRITE) ? wdat_q : {DATA_W{1'bz}};

    assign cs     = cs_q;
    assign wr     = wr_q;
    assign add    = add_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_ram_inout_arbiter.sv
// Randomized bench for ram_inout_arbiter: RAM environment, two master agents and a transaction-level reference model.
module tb_ram_inout_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          scr;
    } op_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, cs, wr;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] add;
    wire  [DW-1:0] data_bus;

    int n_chk = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;
    logic ram_clr = 1'b1;
    op_t q0[$];
    op_t q1[$];

    always #5 clk = ~clk;

    ram_inout_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .cs(cs), .wr(wr), .add(add), .data(data_bus)
    );

    // RAM environment; drives 0 on the released bus so any stray arbiter drive shows up.
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (cs && wr) begin
            ram[add] <= data_bus;
        end
    end
    assign data_bus = (cs && wr) ? {DW{1'bz}} : ((cs && !wr) ? ram[add] : {DW{1'b0}});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: one transaction at a time, tracked by cycle offset since its grant.
    logic          m_act = 1'b0, m_g = 1'b0, m_wr = 1'b0, m_last = 1'b1;
    int            m_k = 0;
    int            last_k;
    logic [AW-1:0] m_addr = '0, m_add = '0;
    logic [DW-1:0] m_wd = '0, m_rd0 = '0, m_rd1 = '0;
    logic [DW-1:0] exp_mem [16];
    logic          e_cs, e_wr, e_a0, e_a1;
    logic [DW-1:0] e_data;
    int            glog[$];
    int            dlog[$];

    always @(negedge clk) begin
        if (chk_en) begin
            e_cs = 1'b0; e_wr = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0; e_data = '0;
            if (m_act) begin
                last_k = m_wr ? 2 : 3;
                if (m_k < last_k) begin
                    e_cs = 1'b1;
                    e_wr = m_wr;
                    e_data = m_wr ? m_wd : exp_mem[m_addr];
                end else begin
                    e_a0 = !m_g;
                    e_a1 = m_g;
                end
            end
            chk("cs", 32'(cs), 32'(e_cs));
            chk("wr", 32'(wr), 32'(e_wr));
            chk("busy", 32'(busy), 32'(m_act));
            chk("ack0", 32'(ack0), 32'(e_a0));
            chk("ack1", 32'(ack1), 32'(e_a1));
            chk("rdata0", 32'(rdata0), 32'(m_rd0));
            chk("rdata1", 32'(rdata1), 32'(m_rd1));
            chk("add", 32'(add), 32'(m_add));
            chk("data", 32'(data_bus), 32'(e_data));
            if (ack0) dlog.push_back(0);
            if (ack1) dlog.push_back(1);
        end
        if (ram_clr) for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        if (m_act && m_wr && m_k == 1) exp_mem[m_addr] = m_wd;
        if (rst) begin
            m_act = 1'b0; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0; m_add = '0;
        end else if (m_act) begin
            if (!m_wr && m_k == 2) begin
                if (m_g) m_rd1 = exp_mem[m_addr];
                else     m_rd0 = exp_mem[m_addr];
            end
            if (m_k == (m_wr ? 2 : 3)) m_act = 1'b0;
            else m_k++;
        end else if (req0 || req1) begin
            m_g    = (req0 && req1) ? !m_last : req1;
            m_last = m_g;
            m_act  = 1'b1;
            m_k    = 1;
            m_wr   = m_g ? wr1 : wr0;
            m_addr = m_g ? addr1 : addr0;
            m_wd   = m_g ? wdata1 : wdata0;
            m_add  = m_addr;
            glog.push_back(int'(m_g));
        end
    end

    // Master agents: hold the head op until its ack, scramble inputs after the grant when asked.
    initial begin
        logic a0s, a1s;
        logic sc0, sc1;
        sc0 = 1'b0; sc1 = 1'b0;
        forever begin
            @(negedge clk);
            a0s = ack0; a1s = ack1;
            @(posedge clk); #1;
            if (rst) begin
                q0.delete(); q1.delete(); sc0 = 1'b0; sc1 = 1'b0;
            end else begin
                if (a0s && q0.size() > 0) begin void'(q0.pop_front()); sc0 = 1'b0; end
                if (a1s && q1.size() > 0) begin void'(q1.pop_front()); sc1 = 1'b0; end
                if (q0.size() > 0 && q0[0].scr && busy && req0) sc0 = 1'b1;
                if (q1.size() > 0 && q1[0].scr && busy && req1) sc1 = 1'b1;
            end
            req0 = (q0.size() > 0);
            req1 = (q1.size() > 0);
            if (req0) begin
                wr0 = q0[0].wr;
                addr0 = sc0 ? ~q0[0].addr : q0[0].addr;
                wdata0 = sc0 ? ~q0[0].wdata : q0[0].wdata;
            end else begin
                wr0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
            end
            if (req1) begin
                wr1 = q1[0].wr;
                addr1 = sc1 ? ~q1[0].addr : q1[0].addr;
                wdata1 = sc1 ? ~q1[0].wdata : q1[0].wdata;
            end else begin
                wr1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
            end
        end
    end

    task automatic push(input int m, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic s);
        op_t op;
        op = '{wr: w, addr: a, wdata: d, scr: s};
        if (m == 0) q0.push_back(op);
        else        q1.push_back(op);
    endtask

    task automatic observe(input int n, output int cs_first, output int cs_cnt,
                           output int a0_off, output int a1_off,
                           output logic [DW-1:0] d_first, output logic [DW-1:0] rd0_ack);
        cs_first = -1; cs_cnt = 0; a0_off = -1; a1_off = -1; d_first = '0; rd0_ack = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (cs && cs_first < 0) begin cs_first = i; d_first = data_bus; end
            if (cs) cs_cnt++;
            if (ack0 && a0_off < 0) begin a0_off = i; rd0_ack = rdata0; end
            if (ack1 && a1_off < 0) a1_off = i;
        end
    endtask

    task automatic wait_idle(input string nm, input int bound);
        logic done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk); #2;
            if (q0.size() == 0 && q1.size() == 0 && !req0 && !req1 && !busy) done = 1'b1;
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
    endtask

    initial begin
        int csf, csn, a0o, a1o;
        logic [DW-1:0] df, rd0;
        logic found;

        repeat (2) @(posedge clk);
        #2; rst = 1'b0; ram_clr = 1'b0; chk_en = 1'b1;
        chk("rst_cs", 32'(cs), 0);
        chk("rst_wr", 32'(wr), 0);
        chk("rst_add", 32'(add), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acks", 32'({ack0, ack1}), 0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 0);
        chk("rst_bus", 32'(data_bus), 0);

        // Single write then read by master 0.
        @(posedge clk); #2; push(0, 1'b1, 4'd3, 8'hA5, 1'b0);
        observe(8, csf, csn, a0o, a1o, df, rd0);
        chk("t1_wr_cs_off", 32'(csf), 2);
        chk("t1_wr_cs_cnt", 32'(csn), 1);
        chk("t1_wr_data", 32'(df), 32'hA5);
        chk("t1_wr_ack_off", 32'(a0o), 3);
        @(posedge clk); #2; push(0, 1'b0, 4'd3, 8'h00, 1'b0);
        observe(8, csf, csn, a0o, a1o, df, rd0);
        chk("t1_rd_cs_cnt", 32'(csn), 2);
        chk("t1_rd_ack_off", 32'(a0o), 4);
        chk("t1_rd_data", 32'(rd0), 32'hA5);

        // Tie right after reset: master 0 first, master 1 after a turnaround cycle.
        pulse_reset();
        @(posedge clk); #2;
        push(0, 1'b1, 4'd1, 8'h11, 1'b0);
        push(1, 1'b1, 4'd2, 8'h22, 1'b0);
        observe(10, csf, csn, a0o, a1o, df, rd0);
        chk("t2_ack0_off", 32'(a0o), 3);
        chk("t2_ack1_off", 32'(a1o), 6);
        chk("t2_cs_cnt", 32'(csn), 2);

        // Fairness: 8 reads each, continuously requested.
        glog.delete(); dlog.delete();
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) begin
            push(0, 1'b0, AW'($urandom), 8'h00, 1'b0);
            push(1, 1'b0, AW'($urandom), 8'h00, 1'b0);
        end
        wait_idle("t3_idle", 200);
        chk("t3_grants", 32'(glog.size()), 16);
        chk("t3_acks", 32'(dlog.size()), 16);
        for (int i = 0; i < 16 && i < dlog.size() && i < glog.size(); i++) begin
            chk("t3_grant_order", 32'(glog[i]), 32'(i % 2));
            chk("t3_ack_order", 32'(dlog[i]), 32'(i % 2));
        end

        // Master 1 writes addr 15, master 0 reads it straight after.
        @(posedge clk); #2; push(1, 1'b1, 4'd15, 8'h3C, 1'b0);
        @(posedge clk); #2; push(0, 1'b0, 4'd15, 8'h00, 1'b0);
        wait_idle("t4_idle", 50);
        chk("t4_rdata0", 32'(rdata0), 32'h3C);

        // Reset during READ2.
        @(posedge clk); #2; push(0, 1'b0, 4'd2, 8'h00, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #2;
            if (cs) found = 1'b1;
        end
        chk("t5_read_started", 32'(found), 1);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2;
        chk("t5_cs", 32'(cs), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ack0", 32'(ack0), 0);
        chk("t5_rdata0", 32'(rdata0), 0);
        rst = 1'b0;
        @(posedge clk); #2; push(0, 1'b0, 4'd15, 8'h00, 1'b0);
        wait_idle("t5_idle", 50);
        chk("t5_after_rdata0", 32'(rdata0), 32'h3C);

        // Inputs change after the grant; the latched write must land.
        @(posedge clk); #2; push(0, 1'b1, 4'd5, 8'h77, 1'b1);
        wait_idle("t6_wr_idle", 50);
        @(posedge clk); #2; push(0, 1'b0, 4'd5, 8'h00, 1'b0);
        wait_idle("t6_rd_idle", 50);
        chk("t6_rdata0", 32'(rdata0), 32'h77);

        // Random traffic from both masters.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            if (q0.size() < 2 && $urandom_range(0, 2) == 0)
                push(0, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));
            if (q1.size() < 2 && $urandom_range(0, 2) == 0)
                push(1, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));
        end
        wait_idle("t7_idle", 500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
